// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
//   Bundles the ID/EX fields that the hazard scheduler reads and the
//   stall/flush/mul-div control signals that it drives.
//   master : pipeline side. It drives the decoded ID/EX fields and reads the controls.
//   slave  : hazard_stall_ctrl. It reads the fields and drives the controls.
//   Signals:
//     id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
//     id_md_start_i, id_md_is_div_i, id_hilo_acc_i, id_syscall_i : ID-stage fields
//     ex_memRead_i, ex_rd_i, ex_branch_taken_i                  : EX-stage fields
//     pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o     : pipeline control
//     md_start_o, md_is_div_o, md_busy_o, md_done_o             : mul/div sequencing
interface hazard_stall_ctrl_if;
    logic       id_valid_i;
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rs_i;
    logic       id_uses_rt_i;
    logic       id_md_start_i;
    logic       id_md_is_div_i;
    logic       id_hilo_acc_i;
    logic       id_syscall_i;
    logic       ex_memRead_i;
    logic [4:0] ex_rd_i;
    logic       ex_branch_taken_i;
    logic       pc_stall_o;
    logic       ifid_stall_o;
    logic       idex_bubble_o;
    logic       ifid_flush_o;
    logic       md_start_o;
    logic       md_is_div_o;
    logic       md_busy_o;
    logic       md_done_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               id_md_start_i, id_md_is_div_i, id_hilo_acc_i, id_syscall_i,
               ex_memRead_i, ex_rd_i, ex_branch_taken_i,
        input  pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o,
               md_start_o, md_is_div_o, md_busy_o, md_done_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               id_md_start_i, id_md_is_div_i, id_hilo_acc_i, id_syscall_i,
               ex_memRead_i, ex_rd_i, ex_branch_taken_i,
        output pc_stall_o, ifid_stall_o, idex_bubble_o, ifid_flush_o,
               md_start_o, md_is_div_o, md_busy_o, md_done_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush scheduler for the 5-stage MIPS pipeline. It sits beside ID.
//   It detects load-use hazards and holds instructions in ID while the
//   shared HI/LO mul/div unit is busy. It also sequences that unit's start
//   pulse and latency, and drains the pipeline for DRAIN_CYCLES after a
//   SYSCALL. A taken branch in EX takes priority over every stall.
//   Ports:
//     clk_i : core clock
//     rst_i : synchronous, active-high reset
//     bus   : hazard_stall_ctrl_if.slave. It carries the ID/EX fields in and the controls out.
//   All stall and flush outputs are combinational from the inputs and state.
module hazard_stall_ctrl #(
    parameter int MULT_LAT     = 4,
    parameter int DIV_LAT      = 33,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_stall_ctrl_if.slave   bus
);
    localparam logic [5:0] MULT_CNT  = 6'(MULT_LAT);
    localparam logic [5:0] DIV_CNT   = 6'(DIV_LAT);
    localparam logic [2:0] DRAIN_CNT = 3'(DRAIN_CYCLES);

    typedef enum logic { MD_IDLE, MD_RUN } md_state_t;
    typedef enum logic { RUN, DRAIN } dr_state_t;

    md_state_t  md_state;
    logic [5:0] md_cnt;
    dr_state_t  dr_state;
    logic [2:0] dr_cnt;

    logic load_use;
    logic md_busy;
    logic md_haz;
    logic drain;
    logic stall;
    logic br;
    logic accept;
    logic md_issue;
    logic sys_accept;

    always_comb begin
        // A load to $0 produces nothing to wait for.
        load_use = bus.ex_memRead_i && (bus.ex_rd_i != 5'd0) && bus.id_valid_i &&
                   ((bus.id_uses_rs_i && (bus.id_rs_i == bus.ex_rd_i)) ||
                    (bus.id_uses_rt_i && (bus.id_rt_i == bus.ex_rd_i)));
        md_busy  = (md_state == MD_RUN);
        // HI/LO readers/writers and new mul/div ops wait for the unit to finish.
        md_haz   = bus.id_valid_i && md_busy && (bus.id_md_start_i || bus.id_hilo_acc_i);
        drain    = (dr_state == DRAIN);
        stall    = load_use || md_haz || drain;
        br       = bus.ex_branch_taken_i;
        // Nothing is accepted while reset is held. A flushed ID instruction is
        // never accepted, so it can neither start the unit nor trigger a drain.
        accept     = bus.id_valid_i && !stall && !br && !rst_i;
        md_issue   = accept && bus.id_md_start_i;
        sys_accept = accept && bus.id_syscall_i;
    end

    // A flush overrides the PC/IF-ID hold so that the branch target can be fetched.
    assign bus.pc_stall_o    = !rst_i && stall && !br;
    assign bus.ifid_stall_o  = !rst_i && stall && !br;
    assign bus.idex_bubble_o = !rst_i && (stall || br);
    assign bus.ifid_flush_o  = !rst_i && br;
    assign bus.md_start_o    = md_issue;
    assign bus.md_is_div_o   = md_issue && bus.id_md_is_div_i;
    assign bus.md_busy_o     = !rst_i && md_busy;
    assign bus.md_done_o     = !rst_i && md_busy && (md_cnt == 6'd1);

    // The mul/div latency counter. Once an operation is issued, it runs to
    // completion whatever stalls or flushes occur. Only reset stops it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            md_state <= MD_IDLE;
            md_cnt   <= 6'd0;
        end else if (md_state == MD_IDLE) begin
            if (md_issue) begin
                md_state <= MD_RUN;
                md_cnt   <= bus.id_md_is_div_i ? DIV_CNT : MULT_CNT;
            end
        end else begin
            if (md_cnt == 6'd1) begin
                md_state <= MD_IDLE;
                md_cnt   <= 6'd0;
            end else begin
                md_cnt <= md_cnt - 6'd1;
            end
        end
    end

    // The SYSCALL drain. It is independent of the mul/div unit. A taken branch
    // during DRAIN is a protocol violation, and the drain continues anyway.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dr_state <= RUN;
            dr_cnt   <= 3'd0;
        end else if (dr_state == RUN) begin
            if (sys_accept) begin
                dr_state <= DRAIN;
                dr_cnt   <= DRAIN_CNT;
            end
        end else begin
            if (dr_cnt == 3'd1) begin
                dr_state <= RUN;
                dr_cnt   <= 3'd0;
            end else begin
                dr_cnt <= dr_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
    localparam int MULT_LAT     = 4;
    localparam int DIV_LAT      = 33;
    localparam int DRAIN_CYCLES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_LAT    (MULT_LAT),
        .DIV_LAT     (DIV_LAT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference model. Time stamps stand in for the counters: the unit is busy
    // through cycle md_end, and the drain stalls through cycle dr_end.
    int cyc    = 0;
    int md_end = -1;
    int dr_end = -1;

    always @(negedge clk) begin : model
        logic lu, busy, done, drn, mh, stl, br, acc;
        logic e_pc, e_bub, e_fl, e_st, e_dv, e_by, e_dn;
        lu   = bus.ex_memRead_i && (bus.ex_rd_i != 0) && bus.id_valid_i &&
               ((bus.id_uses_rs_i && bus.id_rs_i == bus.ex_rd_i) ||
                (bus.id_uses_rt_i && bus.id_rt_i == bus.ex_rd_i));
        busy = (cyc <= md_end);
        done = (cyc == md_end);
        drn  = (cyc <= dr_end);
        mh   = bus.id_valid_i && busy && (bus.id_md_start_i || bus.id_hilo_acc_i);
        stl  = lu || mh || drn;
        br   = bus.ex_branch_taken_i;
        acc  = bus.id_valid_i && !stl && !br && !rst;
        e_pc  = !rst && stl && !br;
        e_bub = !rst && (stl || br);
        e_fl  = !rst && br;
        e_st  = acc && bus.id_md_start_i;
        e_dv  = e_st && bus.id_md_is_div_i;
        e_by  = !rst && busy;
        e_dn  = !rst && done;
        chk("pc_stall",    bus.pc_stall_o,    e_pc);
        chk("ifid_stall",  bus.ifid_stall_o,  e_pc);
        chk("idex_bubble", bus.idex_bubble_o, e_bub);
        chk("ifid_flush",  bus.ifid_flush_o,  e_fl);
        chk("md_start",    bus.md_start_o,    e_st);
        chk("md_is_div",   bus.md_is_div_o,   e_dv);
        chk("md_busy",     bus.md_busy_o,     e_by);
        chk("md_done",     bus.md_done_o,     e_dn);
        if (rst) begin
            md_end = -1;
            dr_end = -1;
        end else begin
            if (e_st) md_end = cyc + (bus.id_md_is_div_i ? DIV_LAT : MULT_LAT);
            if (acc && bus.id_syscall_i) dr_end = cyc + DRAIN_CYCLES;
        end
        cyc++;
    end

    task automatic idle();
        bus.id_valid_i = 0; bus.id_rs_i = 0; bus.id_rt_i = 0;
        bus.id_uses_rs_i = 0; bus.id_uses_rt_i = 0;
        bus.id_md_start_i = 0; bus.id_md_is_div_i = 0; bus.id_hilo_acc_i = 0;
        bus.id_syscall_i = 0; bus.ex_memRead_i = 0; bus.ex_rd_i = 0;
        bus.ex_branch_taken_i = 0;
    endtask

    task automatic settle(); @(negedge clk); endtask
    task automatic adv(); @(posedge clk); #1; endtask

    task automatic issue(input logic is_div);
        idle();
        bus.id_valid_i = 1; bus.id_md_start_i = 1; bus.id_md_is_div_i = is_div;
    endtask

    initial begin
        idle();
        rst = 1;
        // Reset state
        settle();
        chk("rst_pc_stall", bus.pc_stall_o, 1'b0);
        chk("rst_busy", bus.md_busy_o, 1'b0);
        adv(); adv();
        rst = 0;

        // Load-use: lw $5 in EX, add reading $5 in ID
        bus.id_valid_i = 1; bus.id_uses_rs_i = 1; bus.id_rs_i = 5;
        bus.ex_memRead_i = 1; bus.ex_rd_i = 5;
        settle();
        chk("lu_pc_stall", bus.pc_stall_o, 1'b1);
        chk("lu_ifid_stall", bus.ifid_stall_o, 1'b1);
        chk("lu_bubble", bus.idex_bubble_o, 1'b1);
        adv();
        bus.ex_memRead_i = 0; bus.ex_rd_i = 0;
        settle();
        chk("lu_once", bus.pc_stall_o, 1'b0);
        adv();
        bus.ex_memRead_i = 1; bus.ex_rd_i = 0; bus.id_rs_i = 0;
        settle();
        chk("lu_r0", bus.pc_stall_o, 1'b0);
        adv();

        // Mult then MFLO
        issue(1'b0);
        settle();
        chk("mul_start", bus.md_start_o, 1'b1);
        chk("mul_isdiv", bus.md_is_div_o, 1'b0);
        adv();
        bus.id_md_start_i = 0; bus.id_hilo_acc_i = 1;
        for (int i = 1; i <= MULT_LAT; i++) begin
            settle();
            chk("mflo_stall", bus.pc_stall_o, 1'b1);
            chk("mul_busy", bus.md_busy_o, 1'b1);
            chk("mul_done", bus.md_done_o, logic'(i == MULT_LAT));
            adv();
        end
        settle();
        chk("mflo_accept", bus.pc_stall_o, 1'b0);
        chk("mul_idle", bus.md_busy_o, 1'b0);
        adv();

        // Back-to-back div
        issue(1'b1);
        settle();
        chk("div1_start", bus.md_start_o, 1'b1);
        chk("div1_isdiv", bus.md_is_div_o, 1'b1);
        adv();
        for (int i = 1; i <= DIV_LAT; i++) begin
            settle();
            chk("div2_stall", bus.pc_stall_o, 1'b1);
            chk("div2_nostart", bus.md_start_o, 1'b0);
            adv();
        end
        settle();
        chk("div2_start", bus.md_start_o, 1'b1);
        chk("div2_isdiv", bus.md_is_div_o, 1'b1);
        adv();
        idle();
        repeat (DIV_LAT + 1) adv();

        // Flush priority over a mul/div stall
        issue(1'b0);
        adv();
        idle(); bus.id_valid_i = 1; bus.id_hilo_acc_i = 1;
        settle();
        chk("mfhi_stall", bus.pc_stall_o, 1'b1);
        adv();
        bus.ex_branch_taken_i = 1;
        settle();
        chk("fl_flush", bus.ifid_flush_o, 1'b1);
        chk("fl_pc_stall", bus.pc_stall_o, 1'b0);
        chk("fl_bubble", bus.idex_bubble_o, 1'b1);
        chk("fl_busy", bus.md_busy_o, 1'b1);
        adv();
        idle();
        settle();
        chk("fl_notdone", bus.md_done_o, 1'b0);
        adv();
        settle();
        chk("fl_done", bus.md_done_o, 1'b1);
        adv();
        issue(1'b0); bus.ex_branch_taken_i = 1;
        settle();
        chk("fl_nostart", bus.md_start_o, 1'b0);
        adv();
        idle();
        adv();

        // Syscall drain during a mult
        issue(1'b0);
        adv();
        idle(); bus.id_valid_i = 1; bus.id_syscall_i = 1;
        settle();
        chk("sys_accept", bus.pc_stall_o, 1'b0);
        adv();
        idle(); bus.id_valid_i = 1; bus.id_uses_rs_i = 1; bus.id_rs_i = 7;
        for (int i = 2; i <= 1 + DRAIN_CYCLES; i++) begin
            settle();
            chk("sys_stall", bus.pc_stall_o, 1'b1);
            chk("sys_md_done", bus.md_done_o, logic'(i == MULT_LAT));
            adv();
        end
        settle();
        chk("sys_release", bus.pc_stall_o, 1'b0);
        adv();

        // Reset in the middle of a div
        issue(1'b1);
        adv();
        idle();
        adv();
        rst = 1;
        adv();
        rst = 0;
        settle();
        chk("rr_busy", bus.md_busy_o, 1'b0);
        chk("rr_bubble", bus.idex_bubble_o, 1'b0);
        adv();
        issue(1'b0);
        settle();
        chk("rr_mul_start", bus.md_start_o, 1'b1);
        adv();
        idle();
        for (int i = 5; i <= 40; i++) begin
            settle();
            chk("rr_done", bus.md_done_o, logic'(i == 4 + MULT_LAT));
            adv();
        end

        // Randomised traffic checked by the model
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.id_valid_i        = ($urandom_range(0, 9) != 0);
            bus.id_rs_i           = 5'($urandom_range(0, 3));
            bus.id_rt_i           = 5'($urandom_range(0, 3));
            bus.id_uses_rs_i      = 1'($urandom_range(0, 1));
            bus.id_uses_rt_i      = 1'($urandom_range(0, 1));
            bus.id_md_start_i     = ($urandom_range(0, 5) == 0);
            bus.id_md_is_div_i    = ($urandom_range(0, 3) == 0);
            bus.id_hilo_acc_i     = ($urandom_range(0, 5) == 0);
            bus.id_syscall_i      = ($urandom_range(0, 24) == 0);
            bus.ex_memRead_i      = ($urandom_range(0, 3) == 0);
            bus.ex_rd_i           = 5'($urandom_range(0, 3));
            bus.ex_branch_taken_i = ($urandom_range(0, 11) == 0);
            adv();
        end
        rst = 0;
        idle();
        adv();
        settle();
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
